// File: rtl/me_pkg.sv
// Shared types and constants for the integer-pel motion-estimation search controller.
package me_pkg;

  localparam int SAD_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } mv_t;

endpackage

// File: rtl/sad_min16.sv
// Combinational 16-way unsigned minimum with 4-bit argmin; ties resolve to the lowest index.
// Balanced tree of 2-input stages, each stage prepending one index bit (which half won).
module sad_min16 #(
  parameter int W = me_pkg::SAD_W
) (
  input  logic [16*W-1:0] sad_row,
  output logic [W-1:0]    min_val,
  output logic [3:0]      min_idx
);

  logic [W-1:0] v0 [16];
  logic [W-1:0] v1 [8];
  logic [W-1:0] v2 [4];
  logic [W-1:0] v3 [2];
  logic [0:0]   i1 [8];
  logic [1:0]   i2 [4];
  logic [2:0]   i3 [2];
  logic         take_top;

  genvar k;
  for (k = 0; k < 16; k++) begin : g_l0
    assign v0[k] = sad_row[k*W +: W];
  end

  // Strict '<' keeps the lower-index (left) operand on equality.
  for (k = 0; k < 8; k++) begin : g_l1
    logic take_b;
    assign take_b = v0[2*k+1] < v0[2*k];
    assign v1[k]  = take_b ? v0[2*k+1] : v0[2*k];
    assign i1[k]  = take_b;
  end

  for (k = 0; k < 4; k++) begin : g_l2
    logic take_b;
    assign take_b = v1[2*k+1] < v1[2*k];
    assign v2[k]  = take_b ? v1[2*k+1] : v1[2*k];
    assign i2[k]  = take_b ? {1'b1, i1[2*k+1]} : {1'b0, i1[2*k]};
  end

  for (k = 0; k < 2; k++) begin : g_l3
    logic take_b;
    assign take_b = v2[2*k+1] < v2[2*k];
    assign v3[k]  = take_b ? v2[2*k+1] : v2[2*k];
    assign i3[k]  = take_b ? {1'b1, i2[2*k+1]} : {1'b0, i2[2*k]};
  end

  assign take_top = v3[1] < v3[0];
  assign min_val  = take_top ? v3[1] : v3[0];
  assign min_idx  = take_top ? {1'b1, i3[1]} : {1'b0, i3[0]};

endmodule

// File: rtl/me_search_ctrl.sv
// Motion-estimation search sequencer: reduces SEARCH_ROWS rows of 16 SADs to the block's best MV.
// Optional early termination on a small running minimum is enabled by defining ME_EARLY_TERM_EN.
module me_search_ctrl #(
  parameter int SAD_W        = me_pkg::SAD_W,
  parameter int SEARCH_ROWS  = 16,
  parameter int EARLY_THRESH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                sad_valid,
  output logic                sad_ready,
  input  logic [16*SAD_W-1:0] sad_row,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [SAD_W-1:0]    min_sad,
  output logic [3:0]          mv_x,
  output logic [3:0]          mv_y,
  output logic                busy
);

  import me_pkg::*;

  localparam int CW = (SEARCH_ROWS > 1) ? $clog2(SEARCH_ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(SEARCH_ROWS - 1);

  if (SEARCH_ROWS < 1 || SEARCH_ROWS > 16 || EARLY_THRESH < 0) begin : g_bad_cfg
    $error("me_search_ctrl: SEARCH_ROWS must be 1..16 and EARLY_THRESH non-negative");
  end

  state_t          state;
  logic [CW-1:0]   row_cnt;
  mv_t             best_mv;
  logic [SAD_W-1:0] row_min;
  logic [3:0]      row_idx;
  logic            row_better;
  logic            row_stop;
  logic            begin_search;
  logic [SAD_W-1:0] next_min;

  sad_min16 #(.W(SAD_W)) u_min (
    .sad_row (sad_row),
    .min_val (row_min),
    .min_idx (row_idx)
  );

  // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    row_better   = row_min < min_sad;
    next_min     = row_better ? row_min : min_sad;
`ifdef ME_EARLY_TERM_EN
    row_stop     = (row_cnt == LAST_ROW) || (next_min < SAD_W'(EARLY_THRESH));
`else
    row_stop     = (row_cnt == LAST_ROW);
`endif
    begin_search = start && ((state == IDLE) || (state == DONE && res_ready));
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sad_ready <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      row_cnt   <= '0;
      min_sad   <= '1;
      best_mv   <= '0;
    end else if (abort) begin
      state     <= IDLE;
      sad_ready <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (begin_search) begin
      state     <= SEARCH;
      sad_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b1;
      row_cnt   <= '0;
      min_sad   <= '1;
      best_mv   <= '0;
    end else begin
      case (state)
        SEARCH: begin
          if (sad_valid) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_better) begin
              min_sad <= row_min;
              best_mv <= '{x: 4'(row_cnt), y: row_idx};
            end
            if (row_stop) begin
              state     <= DONE;
              sad_ready <= 1'b0;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          sad_ready <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign mv_x = best_mv.x;
  assign mv_y = best_mv.y;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Self-checking bench for me_search_ctrl: randomized windows against a raster-scan reference model.
module tb_me_search_ctrl;

  localparam int SAD_W  = 18;
  localparam int ROWS   = 16;
  localparam int THRESH = 64;
  localparam logic [SAD_W-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst_n;
  logic start = 1'b0, abort = 1'b0, sad_valid = 1'b0, res_ready = 1'b0;
  logic [16*SAD_W-1:0] sad_row = '0;
  logic sad_ready, res_valid, busy;
  logic [SAD_W-1:0] min_sad;
  logic [3:0] mv_x, mv_y;

  int passed = 0;
  int total  = 0;

  logic [SAD_W-1:0] win [ROWS][16];
  logic [SAD_W-1:0] exp_min;
  int exp_x, exp_y, exp_rows;

  always #5 clk = ~clk;

  me_search_ctrl #(.SAD_W(SAD_W), .SEARCH_ROWS(ROWS), .EARLY_THRESH(THRESH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .sad_valid (sad_valid),
    .sad_ready (sad_ready),
    .sad_row   (sad_row),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .min_sad   (min_sad),
    .mv_x      (mv_x),
    .mv_y      (mv_y),
    .busy      (busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16*SAD_W-1:0] pack_row(int r);
    logic [16*SAD_W-1:0] v;
    for (int k = 0; k < 16; k++) v[k*SAD_W +: SAD_W] = win[r][k];
    return v;
  endfunction

  task automatic fill(input int lo, input int hi);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < 16; k++) win[r][k] = SAD_W'($urandom_range(hi, lo));
  endtask

  // Reference: visit candidates in raster order keeping the first strict minimum.
  task automatic model();
    bit stop = 0;
    exp_min = ONES; exp_x = 0; exp_y = 0; exp_rows = ROWS;
    for (int r = 0; r < ROWS && !stop; r++) begin
      for (int k = 0; k < 16; k++)
        if (win[r][k] < exp_min) begin exp_min = win[r][k]; exp_x = r; exp_y = k; end
`ifdef ME_EARLY_TERM_EN
      if (exp_min < THRESH) begin exp_rows = r + 1; stop = 1; end
`endif
    end
  endtask

  task automatic run_block(input string name, input bit skip_start, input bit rand_valid,
                           input bit noisy_start, input int hold, input bit b2b_end);
    int acc = 0;
    int budget = 0;
    model();
    if (!skip_start) begin
      start = 1'b1; tick(); start = 1'b0;
    end
    total++;
    if ({sad_ready, res_valid, busy} !== 3'b101) begin
      $display("FAIL %s_enter: ready/valid/busy=%b, want 101", name, {sad_ready, res_valid, busy});
    end else passed++;
    while (acc < exp_rows && budget < 400) begin
      sad_valid = rand_valid ? 1'($urandom_range(1, 0)) : 1'b1;
      start     = noisy_start ? 1'($urandom_range(1, 0)) : 1'b0;
      sad_row   = pack_row(acc);
      if (sad_valid && sad_ready) acc++;
      tick();
      budget++;
    end
    sad_valid = 1'b0;
    total++;
    if (budget >= 400) $display("FAIL %s_rows: accepted %0d rows, want %0d", name, acc, exp_rows);
    else passed++;
    total++;
    if ({res_valid, sad_ready, busy} !== 3'b101)
      $display("FAIL %s_latency: valid/ready/busy=%b, want 101", name, {res_valid, sad_ready, busy});
    else passed++;
    total++;
    if (min_sad !== exp_min) $display("FAIL %s_min: got %0d, want %0d", name, min_sad, exp_min);
    else passed++;
    total++;
    if (mv_x !== 4'(exp_x) || mv_y !== 4'(exp_y))
      $display("FAIL %s_mv: got (%0d,%0d), want (%0d,%0d)", name, mv_x, mv_y, exp_x, exp_y);
    else passed++;
    for (int i = 0; i < hold; i++) begin
      sad_valid = 1'($urandom_range(1, 0));
      start     = noisy_start ? 1'($urandom_range(1, 0)) : 1'b0;
      sad_row   = pack_row($urandom_range(ROWS - 1, 0));
      tick();
      total++;
      if ({res_valid, sad_ready} !== 2'b10 || min_sad !== exp_min ||
          mv_x !== 4'(exp_x) || mv_y !== 4'(exp_y))
        $display("FAIL %s_hold%0d: valid/ready=%b min=%0d mv=(%0d,%0d), want 10 %0d (%0d,%0d)",
                 name, i, {res_valid, sad_ready}, min_sad, mv_x, mv_y, exp_min, exp_x, exp_y);
      else passed++;
    end
    sad_valid = 1'b0;
    res_ready = 1'b1;
    start     = b2b_end;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    total++;
    if (b2b_end) begin
      if ({sad_ready, res_valid, busy} !== 3'b101 || min_sad !== ONES)
        $display("FAIL %s_b2b: ready/valid/busy=%b min=%0d, want 101 %0d",
                 name, {sad_ready, res_valid, busy}, min_sad, ONES);
      else passed++;
    end else begin
      if ({sad_ready, res_valid, busy} !== 3'b000)
        $display("FAIL %s_release: ready/valid/busy=%b, want 000", name, {sad_ready, res_valid, busy});
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({sad_ready, res_valid, busy} !== 3'b000 || min_sad !== ONES || mv_x !== 4'd0 || mv_y !== 4'd0)
      $display("FAIL reset: ready/valid/busy=%b min=%0d mv=(%0d,%0d), want 000 %0d (0,0)",
               {sad_ready, res_valid, busy}, min_sad, mv_x, mv_y, ONES);
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    tick();
    total++;
    if ({sad_ready, busy} !== 2'b00) $display("FAIL idle: ready/busy=%b, want 00", {sad_ready, busy});
    else passed++;
  endtask

  task automatic test_nominal();
    fill(500, 500);
    win[5][9] = 100;
    run_block("nominal", 0, 0, 0, 0, 0);
  endtask

  task automatic test_ties();
    fill(500, 500);
    win[2][3] = 50; win[7][3] = 50; win[2][1] = 50;
    run_block("ties", 0, 0, 0, 1, 0);
  endtask

  task automatic test_boundaries();
    fill(2**18 - 1, 2**18 - 1);
    win[15][15] = '0;
    run_block("zero_last", 0, 0, 0, 0, 0);
    fill(2**18 - 1, 2**18 - 1);
    win[9][0] = ONES - 1'b1;
    win[12][4] = ONES - 1'b1;
    run_block("full_width", 0, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 3; n++) begin
      fill(100, 2**18 - 1);
      win[$urandom_range(ROWS - 1, 0)][$urandom_range(15, 0)] = SAD_W'($urandom_range(150, 100));
      run_block("backpressure", 0, 1, 1, 10, 0);
    end
  endtask

  task automatic test_abort();
    fill(300, 900);
    win[2][5] = 80;
    start = 1'b1; tick(); start = 1'b0;
    sad_valid = 1'b1;
    for (int r = 0; r < 7; r++) begin
      sad_row = pack_row(r);
      tick();
    end
    abort = 1'b1; sad_row = pack_row(7);
    tick();
    abort = 1'b0;
    total++;
    if ({sad_ready, res_valid, busy} !== 3'b000)
      $display("FAIL abort: ready/valid/busy=%b, want 000", {sad_ready, res_valid, busy});
    else passed++;
    for (int i = 0; i < 6; i++) begin
      sad_row = pack_row(8 + i);
      tick();
      total++;
      if ({sad_ready, res_valid} !== 2'b00)
        $display("FAIL abort_idle%0d: ready/valid=%b, want 00", i, {sad_ready, res_valid});
      else passed++;
    end
    sad_valid = 1'b0;
    fill(2**18 - 1, 2**18 - 1);
    run_block("after_abort", 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    fill(300, 5000);
    win[11][2] = 5;
    run_block("b2b_first", 0, 0, 0, 3, 1);
    fill(300, 5000);
    run_block("b2b_second", 1, 1, 0, 0, 0);
  endtask

  task automatic test_early_term();
    fill(500, 500);
    win[3][6] = 10;
    run_block("early", 0, 0, 0, 4, 0);
  endtask

  task automatic test_mid_reset();
    fill(400, 900);
    win[1][4] = 200;
    start = 1'b1; tick(); start = 1'b0;
    sad_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      sad_row = pack_row(r);
      tick();
    end
    sad_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sad_ready, res_valid, busy} !== 3'b000 || min_sad !== ONES || mv_x !== 4'd0 || mv_y !== 4'd0)
      $display("FAIL mid_reset: ready/valid/busy=%b min=%0d mv=(%0d,%0d), want 000 %0d (0,0)",
               {sad_ready, res_valid, busy}, min_sad, mv_x, mv_y, ONES);
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ties();
    test_boundaries();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_early_term();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
